// File: rtl/hilo_pkg.sv
// hilo_pkg: shared types and op encoding for the HI/LO commit pipe.
package hilo_pkg;

    localparam int HILO_DW = 32;

    typedef struct packed {
        logic               v;
        logic               whi;
        logic               wlo;
        logic [HILO_DW-1:0] hi;
        logic [HILO_DW-1:0] lo;
    } hilo_entry_t;

    typedef enum logic [2:0] {
        HILO_OP_NONE,
        HILO_OP_MUL,
        HILO_OP_MTHI,
        HILO_OP_MTLO,
        HILO_OP_MADD,
        HILO_OP_MSUB
    } hilo_op_e;

    // Builds a pipe entry; mthi/mtlo pass the rs value in both halves and rely on whi/wlo.
    function automatic hilo_entry_t hilo_encode(input hilo_op_e op, input logic [2*HILO_DW-1:0] val);
        hilo_entry_t e;
        e.v   = op != HILO_OP_NONE;
        e.whi = e.v && op != HILO_OP_MTLO;
        e.wlo = e.v && op != HILO_OP_MTHI;
        e.hi  = val[2*HILO_DW-1:HILO_DW];
        e.lo  = val[HILO_DW-1:0];
        return e;
    endfunction

endpackage

// File: rtl/hilo_fwd_mux.sv
// hilo_fwd_mux: youngest-first select of one HI/LO half (P1, then P2, then architectural).
module hilo_fwd_mux
    import hilo_pkg::*;
#(
    parameter int DW = HILO_DW
) (
    input  logic          i_p1_sel,
    input  logic [DW-1:0] i_p1,
    input  logic          i_p2_sel,
    input  logic [DW-1:0] i_p2,
    input  logic [DW-1:0] i_arch,
    output logic [DW-1:0] o_data
);

    assign o_data = i_p1_sel ? i_p1 : i_p2_sel ? i_p2 : i_arch;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: two-stage HI/LO commit pipe with EX-stage forwarding.
// Optional HILO_MADD_EN adds madd/maddu/msub/msubu accumulate ops.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int DW = HILO_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid_i,
    input  logic [2*DW-1:0] mul_prod_i,
    input  logic            mthi_i,
    input  logic            mtlo_i,
    input  logic [DW-1:0]   mt_data_i,
`ifdef HILO_MADD_EN
    input  logic            madd_i,
    input  logic            maddu_i,
    input  logic            msub_i,
    input  logic            msubu_i,
`endif
    input  logic            flush_i,
    input  logic            stall_i,
    output logic [DW-1:0]   hi_fwd_o,
    output logic [DW-1:0]   lo_fwd_o,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic            busy_o
);

    hilo_entry_t     r_p1, r_p2, w_ex;
    logic [DW-1:0]   r_hi, r_lo;
    hilo_op_e        w_op;
    logic [2*DW-1:0] w_base, w_val;

    always_comb begin
`ifdef HILO_MADD_EN
        w_op = mul_valid_i         ? HILO_OP_MUL  :
               (madd_i | maddu_i)  ? HILO_OP_MADD :
               (msub_i | msubu_i)  ? HILO_OP_MSUB :
               mthi_i              ? HILO_OP_MTHI :
               mtlo_i              ? HILO_OP_MTLO : HILO_OP_NONE;
`else
        w_op = mul_valid_i ? HILO_OP_MUL  :
               mthi_i      ? HILO_OP_MTHI :
               mtlo_i      ? HILO_OP_MTLO : HILO_OP_NONE;
`endif
        // Accumulate base is the forwarded value so back-to-back madds chain.
        w_base = {hi_fwd_o, lo_fwd_o};
        w_val  = (w_op == HILO_OP_MADD) ? w_base + mul_prod_i :
                 (w_op == HILO_OP_MSUB) ? w_base - mul_prod_i :
                 (w_op == HILO_OP_MUL)  ? mul_prod_i : {mt_data_i, mt_data_i};
        w_ex   = hilo_encode(w_op, w_val);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_hi <= '0;
            r_lo <= '0;
        end else if (flush_i) begin
            r_p1.v <= 1'b0;
            r_p2.v <= 1'b0;
        end else if (!stall_i) begin
            r_p1 <= w_ex;
            r_p2 <= r_p1;
            if (r_p2.v && r_p2.whi) r_hi <= r_p2.hi;
            if (r_p2.v && r_p2.wlo) r_lo <= r_p2.lo;
        end
    end

    hilo_fwd_mux #(.DW(DW)) u_hi_mux (
        .i_p1_sel (r_p1.v & r_p1.whi),
        .i_p1     (r_p1.hi),
        .i_p2_sel (r_p2.v & r_p2.whi),
        .i_p2     (r_p2.hi),
        .i_arch   (r_hi),
        .o_data   (hi_fwd_o)
    );

    hilo_fwd_mux #(.DW(DW)) u_lo_mux (
        .i_p1_sel (r_p1.v & r_p1.wlo),
        .i_p1     (r_p1.lo),
        .i_p2_sel (r_p2.v & r_p2.wlo),
        .i_p2     (r_p2.lo),
        .i_arch   (r_lo),
        .o_data   (lo_fwd_o)
    );

    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
    assign busy_o = r_p1.v | r_p2.v;

endmodule
